// File: rtl/psum_pkg.sv
// Shared constants and types for the partial-sum writeback path.
package psum_pkg;

  localparam int unsigned LANES  = 10;
  localparam int unsigned PSUM_W = 22;
  localparam int unsigned OUT_W  = 8;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned BUS_W  = LANES * PSUM_W;

  typedef enum logic {IDLE, DRAIN} state_t;

  // LSB position of lane k inside the packed toPsum bus.
  function automatic int unsigned lane_lsb(input int unsigned k);
    return k * PSUM_W;
  endfunction

endpackage

// File: rtl/psum_requant.sv
// One-lane requantizer: ReLU, rounding right shift, clip to OUT_W bits.
module psum_requant #(
  parameter int unsigned PSUM_W = psum_pkg::PSUM_W,
  parameter int unsigned OUT_W  = psum_pkg::OUT_W
) (
  input  logic [PSUM_W-1:0] i_x,
  input  logic [4:0]        i_shift,
  output logic [OUT_W-1:0]  o_data,
  output logic              o_sat
);
  import psum_pkg::*;

  localparam int unsigned W1  = PSUM_W + 1;
  localparam int unsigned MAX = (1 << OUT_W) - 1;

  logic [W1-1:0] w_rnd;
  logic [W1-1:0] w_ext;
  logic [W1-1:0] w_r;
  logic          w_neg;

  // One extra bit keeps x + half-LSB from overflowing for positive x.
  assign w_neg = i_x[PSUM_W-1];
  assign w_rnd = (i_shift == 5'd0) ? '0 : (W1'(1) << (i_shift - 5'd1));
  assign w_ext = {1'b0, i_x} + w_rnd;
  assign w_r   = w_ext >> i_shift;

  assign o_sat  = !w_neg && (w_r > W1'(MAX));
  assign o_data = w_neg ? '0 : (o_sat ? '1 : w_r[OUT_W-1:0]);

endmodule

// File: rtl/psum_writeback.sv
// Captures a packed psum word and drains it lane by lane to the ofmap buffer.
// Optional PSUM_SAT_STATS_EN adds a saturating count of clipped beats.
module psum_writeback #(
  parameter int unsigned LANES  = psum_pkg::LANES,
  parameter int unsigned PSUM_W = psum_pkg::PSUM_W,
  parameter int unsigned OUT_W  = psum_pkg::OUT_W,
  parameter int unsigned ADDR_W = psum_pkg::ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    psum_valid,
  output logic                    psum_ready,
  input  logic [LANES*PSUM_W-1:0] psum_in,
  input  logic [LANES-1:0]        lane_mask,
  input  logic [4:0]              shift,
  input  logic                    frame_start,
  input  logic [ADDR_W-1:0]       base_addr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic [ADDR_W-1:0]       out_addr,
  output logic [15:0]             out_count
`ifdef PSUM_SAT_STATS_EN
  ,
  output logic [15:0]             sat_count
`endif
);
  import psum_pkg::*;

  localparam int unsigned IDX_W = $clog2(LANES);

  state_t                         r_state;
  logic [LANES-1:0][PSUM_W-1:0]   r_lane;
  logic [LANES-1:0]               r_mask;
  logic [4:0]                     r_shift;
  logic [IDX_W-1:0]               r_idx;
  logic [ADDR_W-1:0]              r_addr;
  logic [15:0]                    r_count;

  logic [PSUM_W-1:0] w_lane;
  logic [OUT_W-1:0]  w_q;
  logic              w_sat;
  logic              w_beat;
  logic              w_fire;
  logic              w_adv;
  logic              w_last;

  assign w_lane = r_lane[r_idx];
  assign w_beat = (r_state == DRAIN) && r_mask[r_idx];
  assign w_fire = w_beat && out_ready;
  assign w_adv  = (r_state == DRAIN) && (!r_mask[r_idx] || out_ready);
  assign w_last = (r_idx == IDX_W'(LANES - 1));

  psum_requant #(
    .PSUM_W(PSUM_W),
    .OUT_W (OUT_W)
  ) u_requant (
    .i_x    (w_lane),
    .i_shift(r_shift),
    .o_data (w_q),
    .o_sat  (w_sat)
  );

  assign psum_ready = (r_state == IDLE);
  assign out_valid  = w_beat;
  assign out_data   = w_beat ? w_q : '0;
  assign out_addr   = r_addr;
  assign out_count  = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_lane  <= '0;
      r_mask  <= '0;
      r_shift <= '0;
      r_idx   <= '0;
      r_addr  <= '0;
      r_count <= '0;
    end else if (r_state == IDLE) begin
      // Address load and capture share an edge, so the word starts at base_addr.
      if (frame_start) begin
        r_addr  <= base_addr;
        r_count <= '0;
      end
      if (psum_valid) begin
        r_lane  <= psum_in;
        r_mask  <= lane_mask;
        r_shift <= shift;
        r_idx   <= '0;
        r_state <= DRAIN;
      end
    end else begin
      if (w_fire) begin
        r_addr <= r_addr + ADDR_W'(1);
        if (r_count != '1) r_count <= r_count + 16'd1;
      end
      if (w_adv) begin
        if (w_last) r_state <= IDLE;
        else        r_idx   <= r_idx + IDX_W'(1);
      end
    end
  end

`ifdef PSUM_SAT_STATS_EN
  logic [15:0] r_sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat <= '0;
    end else if (r_state == IDLE) begin
      if (frame_start) r_sat <= '0;
    end else if (w_fire && w_sat && (r_sat != '1)) begin
      r_sat <= r_sat + 16'd1;
    end
  end

  assign sat_count = r_sat;
`else
  logic w_unused_sat;
  assign w_unused_sat = w_sat;
`endif

endmodule

// File: tb/tb_psum_writeback.sv
// Self-checking bench for psum_writeback: queue-based reference model plus directed literals.
module tb_psum_writeback;

  localparam int L  = 10;
  localparam int PW = 22;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            psum_valid = 1'b0;
  logic            psum_ready;
  logic [L*PW-1:0] psum_in = '0;
  logic [L-1:0]    lane_mask = '0;
  logic [4:0]      shift = '0;
  logic            frame_start = 1'b0;
  logic [11:0]     base_addr = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [7:0]      out_data;
  logic [11:0]     out_addr;
  logic [15:0]     out_count;
`ifdef PSUM_SAT_STATS_EN
  logic [15:0]     sat_count;
`endif

  psum_writeback dut (
    .clk        (clk),
    .rst        (rst),
    .psum_valid (psum_valid),
    .psum_ready (psum_ready),
    .psum_in    (psum_in),
    .lane_mask  (lane_mask),
    .shift      (shift),
    .frame_start(frame_start),
    .base_addr  (base_addr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_count  (out_count)
`ifdef PSUM_SAT_STATS_EN
    ,
    .sat_count  (sat_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference requantizer in plain integer arithmetic.
  function automatic int rq(input logic [PW-1:0] x, input int sh, output bit sat);
    longint v, half, r;
    v   = longint'($signed(x));
    sat = 1'b0;
    if (v < 0) return 0;
    half = (sh > 0) ? longint'(2 ** (sh - 1)) : 0;
    r    = (v + half) / longint'(2 ** sh);
    sat  = (r > 255);
    return sat ? 255 : int'(r);
  endfunction

  typedef struct {bit en; int data; bit sat;} lane_t;
  typedef struct {int data; int addr;} beat_t;

  lane_t q[$];
  beat_t dlog[$];
  int    m_addr = 0;
  int    m_count = 0;
  int    m_sat = 0;

  // Compare DUT to model, then advance the model across the coming edge.
  always @(negedge clk) begin
    lane_t e;
    bit    s;
    bit    exp_v;
    exp_v = (q.size() > 0) ? q[0].en : 1'b0;
    chk("psum_ready", psum_ready, q.size() == 0);
    chk("out_valid", out_valid, exp_v);
    chk("out_addr", out_addr, m_addr);
    chk("out_count", out_count, m_count);
    if (exp_v) chk("out_data", out_data, q[0].data);
`ifdef PSUM_SAT_STATS_EN
    chk("sat_count", sat_count, m_sat);
`endif
    if (!rst && out_valid === 1'b1 && out_ready) dlog.push_back('{int'(out_data), int'(out_addr)});

    if (rst) begin
      q.delete();
      m_addr = 0; m_count = 0; m_sat = 0;
    end else if (q.size() == 0) begin
      if (frame_start) begin
        m_addr = base_addr; m_count = 0; m_sat = 0;
      end
      if (psum_valid) begin
        for (int k = 0; k < L; k++) begin
          e.en   = lane_mask[k];
          e.data = rq(psum_in[k*PW +: PW], int'(shift), s);
          e.sat  = s;
          q.push_back(e);
        end
      end
    end else if (!q[0].en) begin
      void'(q.pop_front());
    end else if (out_ready) begin
      m_addr = (m_addr + 1) % 4096;
      if (m_count < 65535) m_count++;
      if (q[0].sat && m_sat < 65535) m_sat++;
      void'(q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (psum_ready !== 1'b1 && n < 300) begin tick(); n++; end
    if (psum_ready !== 1'b1) chk("idle_timeout", psum_ready, 1);
  endtask

  task automatic send(input logic [L*PW-1:0] bus, input logic [L-1:0] m, input logic [4:0] sh);
    wait_idle();
    psum_in = bus; lane_mask = m; shift = sh; psum_valid = 1'b1;
    tick();
    psum_valid = 1'b0;
  endtask

  task automatic drain_len(input string name, input int exp);
    int n = 0;
    while (psum_ready !== 1'b1 && n < 60) begin tick(); n++; end
    chk(name, n, exp);
  endtask

  logic [L*PW-1:0] bus;
  bit pat[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  bit dummy;

  initial begin
    tick(); tick();
    rst = 1'b0;
    chk("rst_ready", psum_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_addr", out_addr, 0);
    chk("rst_count", out_count, 0);

    // Full frame with frame_start in the capture cycle.
    dlog.delete(); bus = '0;
    for (int k = 0; k < L; k++) bus[k*PW +: PW] = PW'(10 * (k + 1));
    frame_start = 1'b1; base_addr = 12'h100;
    send(bus, 10'h3FF, 5'd0);
    frame_start = 1'b0;
    chk("first_beat_valid", out_valid, 1);
    chk("first_beat_data", out_data, 10);
    drain_len("full_drain_cycles", 10);
    chk("full_beats", dlog.size(), 10);
    for (int k = 0; k < dlog.size() && k < L; k++) begin
      chk("full_data", dlog[k].data, 10 * (k + 1));
      chk("full_addr", dlog[k].addr, 32'h100 + k);
    end
    chk("full_count", out_count, 10);

    // Clipping.
    dlog.delete(); bus = '0;
    bus[0 +: PW] = 22'h3FFFFF; bus[PW +: PW] = 22'd300; bus[2*PW +: PW] = 22'd255;
    frame_start = 1'b1; base_addr = 12'h000;
    send(bus, 10'h007, 5'd0);
    frame_start = 1'b0;
    drain_len("clip_drain_cycles", 10);
    chk("clip_beats", dlog.size(), 3);
    if (dlog.size() == 3) begin
      chk("clip_neg", dlog[0].data, 0);
      chk("clip_300", dlog[1].data, 255);
      chk("clip_255", dlog[2].data, 255);
    end
`ifdef PSUM_SAT_STATS_EN
    chk("clip_sat_count", sat_count, 1);
`endif

    // Rounding.
    dlog.delete(); bus = '0;
    bus[0 +: PW] = 22'd6; bus[PW +: PW] = 22'd5; bus[2*PW +: PW] = 22'd1;
    send(bus, 10'h007, 5'd2);
    drain_len("rnd_drain_cycles", 10);
    chk("rnd_beats", dlog.size(), 3);
    if (dlog.size() == 3) begin
      chk("rnd_6", dlog[0].data, 2);
      chk("rnd_5", dlog[1].data, 1);
      chk("rnd_1", dlog[2].data, 0);
    end
    dlog.delete(); bus = '0;
    bus[3*PW +: PW] = 22'h1FFFFF;
    send(bus, 10'h008, 5'd21);
    drain_len("rnd21_drain_cycles", 10);
    chk("rnd21_beats", dlog.size(), 1);
    if (dlog.size() == 1) chk("rnd21_data", dlog[0].data, 1);

    // Sparse mask and empty mask.
    dlog.delete();
    for (int k = 0; k < L; k++) bus[k*PW +: PW] = 22'd1000;
    bus[0 +: PW] = 22'd7; bus[9*PW +: PW] = 22'd9;
    frame_start = 1'b1; base_addr = 12'h000;
    send(bus, 10'b10_0000_0001, 5'd0);
    frame_start = 1'b0;
    drain_len("sparse_drain_cycles", 10);
    chk("sparse_beats", dlog.size(), 2);
    if (dlog.size() == 2) begin
      chk("sparse_d0", dlog[0].data, 7);  chk("sparse_a0", dlog[0].addr, 0);
      chk("sparse_d1", dlog[1].data, 9);  chk("sparse_a1", dlog[1].addr, 1);
    end
    dlog.delete();
    send(bus, 10'h000, 5'd0);
    drain_len("empty_drain_cycles", 10);
    chk("empty_beats", dlog.size(), 0);
    chk("empty_count", out_count, 2);

    // Backpressure, held psum_valid across DRAIN, address wrap.
    dlog.delete();
    for (int k = 0; k < L; k++) bus[k*PW +: PW] = PW'($urandom_range(0, 1000));
    wait_idle();
    frame_start = 1'b1; base_addr = 12'hFFE;
    psum_in = bus; lane_mask = 10'h3FF; shift = 5'd1; psum_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      out_ready = pat[i % 5];
      tick();
      frame_start = 1'b0;
    end
    psum_valid = 1'b0; out_ready = 1'b1;
    wait_idle();
    chk("bp_beats", dlog.size(), 20);
    for (int k = 0; k < dlog.size() && k < 20; k++) begin
      chk("bp_addr", dlog[k].addr, (32'hFFE + k) % 4096);
      chk("bp_data", dlog[k].data, rq(bus[(k % L)*PW +: PW], 1, dummy));
    end
    chk("bp_count", out_count, 20);

    // Reset after three accepted beats.
    dlog.delete(); bus = '0;
    for (int k = 0; k < L; k++) bus[k*PW +: PW] = PW'(k + 1);
    send(bus, 10'h3FF, 5'd0);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_ready", psum_ready, 1);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_addr", out_addr, 0);
    chk("mid_rst_count", out_count, 0);
    chk("mid_rst_beats", dlog.size(), 3);
    dlog.delete();
    for (int k = 0; k < L; k++) bus[k*PW +: PW] = PW'(50 + k);
    send(bus, 10'h3FF, 5'd0);
    drain_len("post_rst_drain_cycles", 10);
    chk("post_rst_beats", dlog.size(), 10);
    if (dlog.size() == 10) begin
      chk("post_rst_d0", dlog[0].data, 50); chk("post_rst_a0", dlog[0].addr, 0);
      chk("post_rst_d9", dlog[9].data, 59); chk("post_rst_a9", dlog[9].addr, 9);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      for (int k = 0; k < L; k++)
        psum_in[k*PW +: PW] = ($urandom_range(0, 3) == 0) ? PW'($urandom) : PW'($urandom_range(0, 700));
      lane_mask   = L'($urandom);
      shift       = 5'($urandom_range(0, 21));
      psum_valid  = ($urandom_range(0, 2) == 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      frame_start = ($urandom_range(0, 19) == 0);
      base_addr   = 12'($urandom);
      rst         = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; psum_valid = 1'b0; frame_start = 1'b0; out_ready = 1'b1;
    wait_idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
